// File: rtl/adc_mul_seq.sv
`default_nettype none
// ---------------------------------------------------------------------------
// adc_mul_seq : unsigned WIDTH x WIDTH -> 2*WIDTH shift-and-add multiply
// sequencer driving an external adder; ZERO_SKIP_EN short-cuts zero operands.
// Revision 1.0
// ---------------------------------------------------------------------------
module adc_mul_seq #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product,
    output logic [WIDTH-1:0]     add_a,
    output logic [WIDTH-1:0]     add_b,
    output logic                 add_c0,
    input  logic [WIDTH-1:0]     add_s,
    input  logic                 add_co
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t               state_q;
    logic [WIDTH-1:0]     m_q;
    logic [WIDTH-1:0]     hi_q;
    logic [WIDTH-1:0]     q_q;
    logic [CNT_W-1:0]     cnt_q;
    logic                 busy_q;
    logic                 done_q;
    logic [2*WIDTH-1:0]   product_q;
    logic [WIDTH-1:0]     hi_d;
    logic [WIDTH-1:0]     q_d;

    // Adder is only driven while iterating; idle/done keep it quiet.
    assign add_a  = (state_q == S_RUN) ? hi_q : '0;
    assign add_b  = (state_q == S_RUN && q_q[0]) ? m_q : '0;
    assign add_c0 = 1'b0;

    // 65-bit right shift of {carry, sum, Q}: carry-out lands in HI's MSB.
    assign hi_d = {add_co, add_s[WIDTH-1:1]};
    assign q_d  = {add_s[0], q_q[WIDTH-1:1]};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            m_q       <= '0;
            hi_q      <= '0;
            q_q       <= '0;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            product_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    busy_q <= 1'b0;
                    done_q <= 1'b0;
                    if (start) begin
                        m_q    <= a;
                        q_q    <= b;
                        hi_q   <= '0;
                        cnt_q  <= '0;
                        busy_q <= 1'b1;
`ifdef ZERO_SKIP_EN
                        if (a == '0 || b == '0) begin
                            state_q   <= S_DONE;
                            done_q    <= 1'b1;
                            product_q <= '0;
                        end else
`endif
                        state_q <= S_RUN;
                    end
                end
                S_RUN: begin
                    hi_q  <= hi_d;
                    q_q   <= q_d;
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(WIDTH - 1)) begin
                        state_q   <= S_DONE;
                        done_q    <= 1'b1;
                        product_q <= {hi_d, q_d};
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign product = product_q;

endmodule
`default_nettype wire
